// File: rtl/sd_write_buf_pkg.sv
// Shared types and helpers for the SD DAT-line write feeder.
package sd_write_buf_pkg;

    localparam int unsigned BlockCountWidth = 16;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_FILL,
        FEED_START,
        FEED_SEND,
        FEED_WAIT_DONE
    } feed_state_e;

    // Number of 32-bit words needed to hold a block of the given byte size.
    function automatic logic [31:0] words_for_bytes(input logic [31:0] bytes);
        return (bytes + 32'd3) >> 2;
    endfunction

endpackage

// File: rtl/write_word_fifo.sv
// Show-ahead synchronous word FIFO with flush; head_o is registered and
// reflects the new head word the cycle after a pop or a push into empty.
module write_word_fifo #(
    parameter int unsigned DepthWords = 128
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          pop_i,
    output logic [31:0]                   head_o,
    output logic [$clog2(DepthWords):0]   count_o,
    output logic [$clog2(DepthWords):0]   count_next_o,
    output logic                          overflow_o,
    output logic                          underrun_o
);

    localparam int unsigned PtrW = $clog2(DepthWords);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     mem_q [DepthWords];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     head_q, head_d;
    logic            full, empty, push_eff, pop_eff;

    // Pointer, occupancy and show-ahead head computation.
    always_comb begin
        full       = (count_q == CntW'(DepthWords));
        empty      = (count_q == '0);
        push_eff   = push_i & ~full & ~flush_i;
        pop_eff    = pop_i & ~empty & ~flush_i;
        overflow_o = push_i & full & ~flush_i;
        underrun_o = pop_i & empty & ~flush_i;
        wr_ptr_d   = wr_ptr_q + (push_eff ? PtrW'(1) : '0);
        rd_ptr_d   = rd_ptr_q + (pop_eff ? PtrW'(1) : '0);
        count_d    = count_q + (push_eff ? CntW'(1) : '0) - (pop_eff ? CntW'(1) : '0);
        head_d     = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else if (pop_eff && count_d != '0) begin
            // The next head may be the word being written this very cycle.
            head_d = (push_eff && rd_ptr_d == wr_ptr_q) ? wr_data_i : mem_q[rd_ptr_d];
        end else if (empty && push_eff) begin
            head_d = wr_data_i;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o       = head_q;
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/dat_write_feeder.sv
// Feeds host-written words to the SD DAT writer a block at a time.
// Optional macro DAT_FEED_BYTE_SWAP_EN byte-reverses data_o for big-endian hosts.
module dat_write_feeder
    import sd_write_buf_pkg::*;
#(
    parameter int unsigned MaxBlockBitSize = 12,
    parameter int unsigned DepthWords      = 128
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       xfer_go_i,
    input  logic [MaxBlockBitSize-1:0] block_size_i,
    input  logic [15:0]                block_count_i,
    input  logic                       multi_block_i,
    input  logic                       abort_i,
    input  logic                       wr_valid_i,
    input  logic [31:0]                wr_data_i,
    output logic                       buf_wr_ready_o,
    output logic                       start_o,
    output logic [31:0]                data_o,
    input  logic                       next_word_i,
    input  logic                       done_i,
    input  logic                       crc_err_i,
    input  logic                       end_bit_err_i,
    output logic                       xfer_done_o,
    output logic                       err_o,
    output logic                       busy_o
);

    localparam int unsigned CntW = $clog2(DepthWords) + 1;

    feed_state_e                state_q, state_d;
    logic [BlockCountWidth-1:0] blocks_left_q, blocks_left_d;
    logic [MaxBlockBitSize:0]   pop_cnt_q, pop_cnt_d;
    logic                       err_q, err_d;
    logic                       xfer_done_q, xfer_done_d;
    logic                       ready_q, ready_d;

    logic [31:0]     blk_words;
    logic [31:0]     head;
    logic [CntW-1:0] fifo_count, fifo_count_next;
    logic            overflow, underrun;

    assign blk_words = words_for_bytes(32'(block_size_i));

    write_word_fifo #(
        .DepthWords (DepthWords)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (abort_i),
        .push_i       (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .pop_i        (next_word_i),
        .head_o       (head),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .overflow_o   (overflow),
        .underrun_o   (underrun)
    );

    // State and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= FEED_IDLE;
            blocks_left_q <= '0;
            pop_cnt_q     <= '0;
            err_q         <= 1'b0;
            xfer_done_q   <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            blocks_left_q <= blocks_left_d;
            pop_cnt_q     <= pop_cnt_d;
            err_q         <= err_d;
            xfer_done_q   <= xfer_done_d;
            ready_q       <= ready_d;
        end
    end

    // Next-state, block/pop counting and sticky error logic.
    always_comb begin
        state_d       = state_q;
        blocks_left_d = blocks_left_q;
        pop_cnt_d     = pop_cnt_q;
        err_d         = err_q | overflow | underrun;
        xfer_done_d   = 1'b0;
        // Ready is computed from next-cycle occupancy so the flop matches the live count.
        ready_d       = (32'(DepthWords) - 32'(fifo_count_next)) >= blk_words;
        if (abort_i) begin
            state_d   = FEED_IDLE;
            pop_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            unique case (state_q)
                FEED_IDLE: begin
                    if (xfer_go_i) begin
                        err_d = overflow | underrun;
                        if (multi_block_i && block_count_i == '0) begin
                            xfer_done_d = 1'b1;
                        end else begin
                            state_d       = FEED_FILL;
                            blocks_left_d = multi_block_i ? block_count_i : BlockCountWidth'(1);
                        end
                    end
                end
                FEED_FILL: begin
                    pop_cnt_d = '0;
                    if (32'(fifo_count) >= blk_words) begin
                        state_d = FEED_START;
                    end
                end
                FEED_START: begin
                    if (next_word_i) begin
                        pop_cnt_d = (MaxBlockBitSize+1)'(1);
                        state_d   = (blk_words <= 32'd1) ? FEED_WAIT_DONE : FEED_SEND;
                    end
                end
                FEED_SEND: begin
                    if (next_word_i) begin
                        pop_cnt_d = pop_cnt_q + 1'b1;
                        if (32'(pop_cnt_q) + 32'd1 >= blk_words) begin
                            state_d = FEED_WAIT_DONE;
                        end
                    end
                end
                FEED_WAIT_DONE: begin
                    if (done_i) begin
                        if (crc_err_i || end_bit_err_i) begin
                            err_d   = 1'b1;
                            state_d = FEED_IDLE;
                        end else begin
                            blocks_left_d = blocks_left_q - 1'b1;
                            if (blocks_left_q == BlockCountWidth'(1)) begin
                                xfer_done_d = 1'b1;
                                state_d     = FEED_IDLE;
                            end else begin
                                state_d = FEED_FILL;
                            end
                        end
                    end
                end
                default: state_d = FEED_IDLE;
            endcase
        end
    end

    // Outputs decoded from state and the FIFO head.
    always_comb begin
        start_o = (state_q == FEED_START);
        busy_o  = (state_q != FEED_IDLE);
`ifdef DAT_FEED_BYTE_SWAP_EN
        data_o  = {head[7:0], head[15:8], head[23:16], head[31:24]};
`else
        data_o  = head;
`endif
    end

    assign xfer_done_o    = xfer_done_q;
    assign err_o          = err_q;
    assign buf_wr_ready_o = ready_q;

endmodule

// File: tb/tb_dat_write_feeder.sv
// Self-checking bench for dat_write_feeder against a queue-based model.
module tb_dat_write_feeder;

    localparam int DEPTH = 128;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        xfer_go_i = 1'b0;
    logic [11:0] block_size_i = 12'd512;
    logic [15:0] block_count_i = 16'd1;
    logic        multi_block_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic [31:0] wr_data_i = '0;
    logic        buf_wr_ready_o;
    logic        start_o;
    logic [31:0] data_o;
    logic        next_word_i = 1'b0;
    logic        done_i = 1'b0;
    logic        crc_err_i = 1'b0;
    logic        end_bit_err_i = 1'b0;
    logic        xfer_done_o;
    logic        err_o;
    logic        busy_o;

    dat_write_feeder #(
        .MaxBlockBitSize (12),
        .DepthWords      (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .xfer_go_i      (xfer_go_i),
        .block_size_i   (block_size_i),
        .block_count_i  (block_count_i),
        .multi_block_i  (multi_block_i),
        .abort_i        (abort_i),
        .wr_valid_i     (wr_valid_i),
        .wr_data_i      (wr_data_i),
        .buf_wr_ready_o (buf_wr_ready_o),
        .start_o        (start_o),
        .data_o         (data_o),
        .next_word_i    (next_word_i),
        .done_i         (done_i),
        .crc_err_i      (crc_err_i),
        .end_bit_err_i  (end_bit_err_i),
        .xfer_done_o    (xfer_done_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] model_q[$];
    logic        exp_err = 1'b0;
    int          cur_bw  = 128;
    int          starts;

    function automatic logic [31:0] host_view(input logic [31:0] w);
`ifdef DAT_FEED_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic ready_model();
        return (DEPTH - model_q.size()) >= cur_bw;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_size(input int bs);
        block_size_i = 12'(bs);
        cur_bw       = (bs + 3) / 4;
    endtask

    task automatic push_word(input logic [31:0] w);
        wr_valid_i = 1'b1;
        wr_data_i  = w;
        tick();
        wr_valid_i = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else exp_err = 1'b1;
        chk1("err_after_push", err_o, exp_err);
        if (model_q.size() > 0) chk("head_after_push", data_o, host_view(model_q[0]));
        chk1("ready_after_push", buf_wr_ready_o, ready_model());
    endtask

    task automatic pop_word();
        next_word_i = 1'b1;
        tick();
        next_word_i = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        else exp_err = 1'b1;
        chk1("err_after_pop", err_o, exp_err);
        if (model_q.size() > 0) chk("head_after_pop", data_o, host_view(model_q[0]));
    endtask

    task automatic go(input int bs, input int cnt, input logic multi);
        set_size(bs);
        block_count_i = 16'(cnt);
        multi_block_i = multi;
        xfer_go_i     = 1'b1;
        tick();
        xfer_go_i = 1'b0;
        exp_err   = 1'b0;
        chk1("err_cleared_by_go", err_o, exp_err);
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        model_q.delete();
        exp_err = 1'b0;
        chk1("abort_busy", busy_o, 1'b0);
        chk1("abort_start", start_o, 1'b0);
        chk1("abort_err", err_o, 1'b0);
        chk1("abort_ready", buf_wr_ready_o, ready_model());
    endtask

    task automatic wait_start();
        for (int k = 0; k < 4 && start_o !== 1'b1; k++) tick();
        chk1("start_raised", start_o, 1'b1);
        if (start_o === 1'b1) starts++;
    endtask

    task automatic run_block(input logic bad);
        chk1("start_low_before_fill", start_o, 1'b0);
        for (int i = 0; i < cur_bw; i++) push_word($urandom);
        wait_start();
        chk1("busy_in_block", busy_o, 1'b1);
        for (int i = 0; i < cur_bw; i++) begin
            pop_word();
            if (i == 0) chk1("start_drops_on_first_pop", start_o, 1'b0);
        end
        chk1("no_done_before_done_i", xfer_done_o, 1'b0);
        done_i    = 1'b1;
        crc_err_i = bad;
        tick();
        done_i    = 1'b0;
        crc_err_i = 1'b0;
        if (bad) exp_err = 1'b1;
        chk1("err_after_block", err_o, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wa, wb;
        int bs;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tick();
        chk1("rst_start", start_o, 1'b0);
        chk1("rst_done", xfer_done_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        chk("rst_data", data_o, 32'h0);
        chk1("rst_ready", buf_wr_ready_o, 1'b1);

        // Single 512-byte block.
        go(512, 1, 1'b0);
        chk1("busy_after_go", busy_o, 1'b1);
        run_block(1'b0);
        chk1("single_done_pulse", xfer_done_o, 1'b1);
        chk1("single_idle", busy_o, 1'b0);
        tick();
        chk1("single_done_one_cycle", xfer_done_o, 1'b0);

        // Three 6-byte blocks.
        starts = 0;
        go(6, 3, 1'b1);
        for (int b = 0; b < 3; b++) begin
            run_block(1'b0);
            chk1("multi_done_only_last", xfer_done_o, (b == 2) ? 1'b1 : 1'b0);
            chk1("multi_busy", busy_o, (b == 2) ? 1'b0 : 1'b1);
        end
        chk("multi_start_count", 32'(starts), 32'd3);
        tick();

        // CRC error on first of two blocks.
        bs = $urandom_range(1, 16);
        go(bs, 2, 1'b1);
        run_block(1'b1);
        chk1("crc_idle", busy_o, 1'b0);
        chk1("crc_no_done", xfer_done_o, 1'b0);
        tick();
        chk1("crc_no_done_later", xfer_done_o, 1'b0);
        chk1("crc_err_sticky", err_o, 1'b1);
        do_abort();

        // Overflow on word 129, then ordered drain in IDLE.
        set_size(512);
        tick();
        for (int i = 0; i < DEPTH + 1; i++) push_word($urandom);
        chk1("overflow_err", err_o, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_word();
        do_abort();
        // Underrun must not move the read pointer.
        pop_word();
        chk1("underrun_err", err_o, 1'b1);
        wa = $urandom;
        wb = $urandom;
        push_word(wa);
        push_word(wb);
        pop_word();
        chk("ptr_after_underrun", data_o, host_view(wb));
        do_abort();

        // Abort in the middle of SEND.
        go(16, 1, 1'b0);
        for (int i = 0; i < cur_bw; i++) push_word($urandom);
        wait_start();
        pop_word();
        pop_word();
        do_abort();
        tick();
        chk1("abort_no_done", xfer_done_o, 1'b0);
        chk1("abort_ready_empty", buf_wr_ready_o, 1'b1);

        // Byte order of the show-ahead word.
        push_word(32'h11223344);
`ifdef DAT_FEED_BYTE_SWAP_EN
        chk("byte_order", data_o, 32'h44332211);
`else
        chk("byte_order", data_o, 32'h11223344);
`endif
        do_abort();

        // Zero-block multi transfer completes at once.
        go(512, 0, 1'b1);
        chk1("zero_blocks_done", xfer_done_o, 1'b1);
        chk1("zero_blocks_idle", busy_o, 1'b0);
        tick();
        chk1("zero_blocks_pulse", xfer_done_o, 1'b0);

        // Abort beats go in the same cycle.
        xfer_go_i = 1'b1;
        abort_i   = 1'b1;
        tick();
        xfer_go_i = 1'b0;
        abort_i   = 1'b0;
        chk1("abort_wins_over_go", busy_o, 1'b0);

        // done_i outside WAIT is ignored.
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk1("stray_done_ignored", xfer_done_o, 1'b0);
        chk1("stray_done_idle", busy_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
